// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: op codes, FSM states and
// the bit-reverse helper used to fold right shifts onto the left-shift datapath.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int LANE_W  = 8;
    localparam int NUM_LANES = DATA_W / LANE_W;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BYTE = 2'b01,
        S_BIT  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/shift_onehot_dec.sv
// 3-bit shift amount to 8-bit one-hot select for the BIT-step slices.
module shift_onehot_dec (
    input  logic [2:0] amt,
    output logic [7:0] sel
);

    assign sel = 8'b0000_0001 << amt;

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle 32-bit shifter: byte-granular shift, then a sub-byte shift
// built from four diagonal 8-bit slices. Right shifts run as reversed left shifts.
module shift_seq_unit
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        err,
    output logic        busy
);

    state_e            state, state_nx;
    shift_op_e         op_q;
    logic [4:0]        sh_q;
    logic              sign_q;
    logic              err_q;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] bit_word;
    logic [DATA_W-1:0] fin_word;
    logic [7:0]        sel;
    logic              accept;

    assign accept = in_valid & in_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    if (shift_op_e'(op) == OP_ILL || shamt == 5'd0) state_nx = S_DONE;
                    else                                           state_nx = S_BYTE;
                end
            end
            S_BYTE: state_nx = S_BIT;
            S_BIT:  state_nx = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- BIT step ----------------
    shift_onehot_dec u_dec (
        .amt (sh_q[2:0]),
        .sel (sel)
    );

    // Each slice sees its own byte plus the byte below it; bits that cross
    // the byte boundary come from the lower half of the window.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_slice
        logic [2*LANE_W-1:0] win;
        logic [LANE_W-1:0]   slc;

        assign win[2*LANE_W-1:LANE_W] = word[LANE_W*l +: LANE_W];
        if (l == 0) begin : g_lo
            assign win[LANE_W-1:0] = '0;
        end else begin : g_hi
            assign win[LANE_W-1:0] = word[LANE_W*(l-1) +: LANE_W];
        end

        always_comb begin
            slc = '0;
            for (int j = 0; j < LANE_W; j++)
                for (int k = 0; k < LANE_W; k++)
                    slc[j] = slc[j] | (sel[k] & win[LANE_W+j-k]);
        end

        assign bit_word[LANE_W*l +: LANE_W] = slc;
    end

    always_comb begin
        fin_word = bit_word;
        if (op_q != OP_SLL) fin_word = bitrev(bit_word);
        if (op_q == OP_SRA && sign_q) fin_word = fin_word | ~(32'hFFFF_FFFF >> sh_q);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_SLL;
            sh_q   <= '0;
            sign_q <= 1'b0;
            word   <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q   <= shift_op_e'(op);
                    sh_q   <= shamt;
                    sign_q <= a[31];
                    word   <= (shift_op_e'(op) == OP_SLL) ? a : bitrev(a);
                    if (shift_op_e'(op) == OP_ILL) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else if (shamt == 5'd0) begin
                        res_q <= a;
                        err_q <= 1'b0;
                    end
                end
                S_BYTE: word <= word << {sh_q[4:3], 3'b000};
                S_BIT: begin
                    word  <= bit_word;
                    res_q <= fin_word;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;
    assign err    = err_q & (state == S_DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit against a plain-arithmetic shift model.
module tb_shift_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        err;
    logic        busy;

    int vec  = 0;
    int errs = 0;

    shift_seq_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // {err, result}
    function automatic logic [32:0] ref_shift(input logic [1:0] o, input logic [31:0] x,
                                              input logic [4:0] s);
        logic signed [31:0] sx;
        logic [31:0] r;
        sx = $signed(x);
        case (o)
            2'b00:   r = x << s;
            2'b01:   r = x >> s;
            2'b10:   r = 32'(sx >>> s);
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, then count cycles until out_valid (bounded).
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s,
                         output int lat);
        int n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        vec++;
        if (in_ready !== 1'b1) begin
            errs++; $display("FAIL issue_in_ready got %b want 1", in_ready);
        end
        in_valid = 1'b1; op = o; a = x; shamt = s;
        tick();
        in_valid = 1'b0; op = 2'($urandom); a = $urandom; shamt = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 10) begin tick(); lat++; end
    endtask

    task automatic consume();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; op = 2'b00; a = 32'h1234_5678; shamt = 5'd3; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        vec++;
        if ({out_valid, err, busy, in_ready} !== 4'b0001) begin
            errs++; $display("FAIL reset_ctrl got ov/err/busy/rdy=%b want 0001",
                             {out_valid, err, busy, in_ready});
        end
        vec++;
        if (result !== 32'h0) begin errs++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_sll31();
        int lat;
        issue(2'b00, 32'h0000_0001, 5'd31, lat);
        vec++;
        if (lat !== 3) begin errs++; $display("FAIL sll31_latency got %0d want 3", lat); end
        vec++;
        if (result !== 32'h8000_0000 || err !== 1'b0) begin
            errs++; $display("FAIL sll31_result got %h/%b want 80000000/0", result, err);
        end
        consume();
        vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++; $display("FAIL sll31_consume got ov=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_sra_srl();
        int lat;
        issue(2'b10, 32'h8000_0000, 5'd4, lat);
        vec++;
        if (lat !== 3 || result !== 32'hF800_0000) begin
            errs++; $display("FAIL sra4 got %h lat %0d want f8000000 lat 3", result, lat);
        end
        consume();
        issue(2'b01, 32'h8000_0000, 5'd4, lat);
        vec++;
        if (lat !== 3 || result !== 32'h0800_0000) begin
            errs++; $display("FAIL srl4 got %h lat %0d want 08000000 lat 3", result, lat);
        end
        consume();
    endtask

    task automatic test_shamt0();
        int lat;
        for (int o = 0; o < 3; o++) begin
            issue(2'(o), 32'hDEAD_BEEF, 5'd0, lat);
            vec++;
            if (lat !== 1 || result !== 32'hDEAD_BEEF || err !== 1'b0) begin
                errs++; $display("FAIL shamt0_op%0d got %h/%b lat %0d want deadbeef/0 lat 1",
                                 o, result, err, lat);
            end
            consume();
        end
    endtask

    task automatic test_illegal_stall();
        int lat;
        issue(2'b11, 32'hFFFF_FFFF, 5'd7, lat);
        vec++;
        if (lat !== 1 || result !== 32'h0 || err !== 1'b1) begin
            errs++; $display("FAIL illegal got %h/%b lat %0d want 0/1 lat 1", result, err, lat);
        end
        in_valid = 1'b1; op = 2'b00; a = 32'h5555_5555; shamt = 5'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++;
            if (out_valid !== 1'b1 || result !== 32'h0 || err !== 1'b1 || in_ready !== 1'b0) begin
                errs++; $display("FAIL illegal_hold%0d got ov=%b res=%h err=%b rdy=%b want 1/0/1/0",
                                 i, out_valid, result, err, in_ready);
            end
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [32:0] e;
        in_valid = 1'b1; op = 2'b00; a = 32'h0F0F_0F0F; shamt = 5'd13;
        tick();
        in_valid = 1'b0;
        tick();
        vec++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errs++; $display("FAIL mid_pre got busy=%b ov=%b want 1/0", busy, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++; $display("FAIL mid_rst got busy=%b ov=%b rdy=%b want 0/0/1", busy, out_valid, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_no_ov%0d got 1 want 0", i); end
        end
        issue(2'b10, 32'h9234_5678, 5'd9, lat);
        e = ref_shift(2'b10, 32'h9234_5678, 5'd9);
        vec++;
        if (lat !== 3 || {err, result} !== e) begin
            errs++; $display("FAIL mid_after got %b/%h lat %0d want %b/%h lat 3",
                             err, result, lat, e[32], e[31:0]);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        int hold;
        logic [1:0]  o;
        logic [31:0] x;
        logic [4:0]  s;
        logic [32:0] e;
        for (int n = 0; n < 60; n++) begin
            o = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            x = $urandom;
            case ($urandom_range(0, 5))
                0:       s = 5'd0;
                1:       s = 5'd31;
                default: s = 5'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) x[31] = 1'b1;
            e = ref_shift(o, x, s);
            issue(o, x, s, lat);
            vec++;
            if ({err, result} !== e || lat !== ((o == 2'b11 || s == 0) ? 1 : 3)) begin
                errs++; $display("FAIL rnd%0d op=%0d a=%h sh=%0d got %b/%h lat %0d want %b/%h",
                                 n, o, x, s, err, result, lat, e[32], e[31:0]);
            end
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom);
                tick();
                vec++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || {err, result} !== e) begin
                    errs++; $display("FAIL rnd%0d_hold got ov=%b rdy=%b %b/%h", n, out_valid,
                                     in_ready, err, result);
                end
            end
            consume();
            vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errs++; $display("FAIL rnd%0d_release got ov=%b rdy=%b want 0/1", n, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; shamt = '0; out_ready = 1'b0;
        test_reset();
        test_sll31();
        test_sra_srl();
        test_shamt0();
        test_illegal_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
